hazard_unit: RTL
================

# hazard_unit

Stall and forwarding controller for the five-stage MIPS pipeline. It consumes the per-instruction Tuse/Tnew codes produced by the decode-stage T-code decoder and keeps a shadow pipeline of destination register and remaining-Tnew for the E, M and W stages. Each cycle it decides whether the instruction in D must stall. When D does not stall, it selects the forwarding source for every operand consumer (D comparator/jr, E ALU, M store data).

## Interface
Parameters:
- `REG_W`, 5: register-address width.

Ports:
- `clk`  in  1  pipeline clock.
- `reset`  in  1  synchronous, active-high; clears all shadow state.
- `rs_d`, `rt_d`  in  REG_W  source registers of the D instruction.
- `tuse_rs`, `tuse_rt`  in  2  cycles until the operand is needed (0 = D, 1 = E, 2 = M); 3 = operand unused.
- `tnew_d`  in  2  cycles from E entry until the result exists (0 = jal link, 1 = ALU, 2 = lw); 3 = no write.
- `dst_d`  in  REG_W  destination register of the D instruction; 0 = no write.
- `stall`  out  1  freeze PC and F/D, insert a bubble into E.
- `fwd_rs_d`, `fwd_rt_d`  out  2  D-stage operand source: 0 RF, 1 E, 2 M, 3 W.
- `fwd_rs_e`, `fwd_rt_e`  out  2  E-stage ALU operand source: 0 pipeline register, 2 M, 3 W.
- `fwd_rt_m`  out  1  M-stage store data: 0 pipeline register, 1 W.

## Operation
- Shadow stage X ∈ {E, M, W} holds `dst_x`, `tnew_x`, `rs_x`, `rt_x`. An entry is live only if `dst_x != 0`.
- On each `clk` without `reset`:
  - W ← M, with tnew saturating-decremented.
  - M ← E, with tnew saturating-decremented.
  - E ← D (`dst_d`, `tnew_d`, `rs_d`, `rt_d`) when `stall == 0`.
  - E ← bubble (dst 0, tnew 3, rs/rt 0) when `stall == 1`.
- A `tnew` value of 3 is never decremented; it always means no write.
- Stall for rs when all of the following hold:
  - `tuse_rs != 3` and `rs_d != 0`
  - and either (`rs_d == dst_e` and `tnew_e > tuse_rs`) or (`rs_d == dst_m` and `tnew_m > tuse_rs`).
- Stall for rt uses the same rule with `rt_d` and `tuse_rt`. `stall` is the OR of the two. The W stage never causes a stall.
- A forward from stage X is eligible when `dst_x == reg`, `reg != 0`, and `tnew_x == 0`. Priority is youngest first (E > M > W for D operands; M > W for E operands).
  - D-stage operand: E → 1, else M → 2, else W → 3, else 0.
  - E-stage operand: compares `rs_e`/`rt_e` against M → 2, else W → 3, else 0.
  - M-stage store data: `rt_m == dst_w`, `rt_m != 0`, `tnew_w == 0` → 1.
- Register 0 never matches, is never forwarded, and never stalls.
- The `rs_x`/`rt_x` values held in M and W are copied along with the rest of the shadow entry.
- When `stall == 1`, the forwarding outputs for D are don't-care. The E and M forwarding outputs stay valid, because those stages keep advancing.

## Timing
- `stall` and every `fwd_*` output are combinational from the D inputs and the current shadow state; they are valid in the same cycle.
- Shadow registers update on the rising edge.
- Worst-case stalls:
  - lw followed by a dependent beq: 2 cycles.
  - lw followed by a dependent ALU instruction: 1 cycle.
  - ALU followed by a dependent beq: 1 cycle.
- Reset values: every shadow `dst` = 0, `tnew` = 3, `rs`/`rt` = 0. Consequently `stall` = 0, all `fwd_*` = 0.
- Reset asserted mid-stall: the next cycle shows clean state and the stall drops.
- Simultaneous matches in several stages: the youngest eligible stage wins. A younger, non-ready match that stalls overrides an older ready one.

## Configuration
- `HAZARD_STATS_EN` defined:
  - adds output `stall_cnt` (32 bits), which counts cycles with `stall == 1`;
  - wraps modulo 2^32;
  - cleared by `reset`.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

## Structure
- Shared package `hazard_pkg`:
  - `TNEW_NONE` = 3, `TUSE_NONE` = 3;
  - forwarding-select constants `FWD_RF`, `FWD_E`, `FWD_M`, `FWD_W`;
  - the shadow-entry struct typedef.
- One sub-module, `hazard_stage_reg`: a single shadow entry with load, bubble and saturating tnew decrement. It is instantiated three times (E, M, W).

## Test plan
- After reset: all outputs 0. Feed `addu $3`; the next instruction reads `$0` with tuse 0 → no stall, `fwd_rs_d` = 0.
- `lw $5`, then `beq $5,$0` → `stall` = 1 for 2 cycles; 3rd cycle `stall` = 0, `fwd_rs_d` = 3 (W).
- `addu $4`, then `addu $6,$4,$4` → no stall; next cycle `fwd_rs_e` = `fwd_rt_e` = 2 (M).
- `jal` (dst 31, tnew 0), then `jr $31` → no stall, `fwd_rs_d` = 1 (E).
- `lw $7`, then `sw $7` (tuse_rt 2) → no stall; when the sw reaches M, `fwd_rt_m` = 1.
- `ori $8` in M and `addu $8` in E, with `beq $8` in D → stall 1 cycle (E not ready), then `fwd_rs_d` = 2. Assert `reset` during a stall → next cycle `stall` = 0; with `HAZARD_STATS_EN`, `stall_cnt` = 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants, shadow-entry type and helper functions for
// the pipeline hazard (stall/forwarding) controller.
package hazard_pkg;

  // Widest register address a shadow entry can hold.
  localparam int SHADOW_REG_W = 5;

  localparam logic [1:0] TNEW_NONE = 2'd3;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  typedef struct packed {
    logic [SHADOW_REG_W-1:0] dst;
    logic [1:0]              tnew;
    logic [SHADOW_REG_W-1:0] rs;
    logic [SHADOW_REG_W-1:0] rt;
  } shadow_t;

  // Bubble: no destination, no pending result, no sources.
  localparam shadow_t SHADOW_EMPTY = '{
    dst:  {SHADOW_REG_W{1'b0}},
    tnew: TNEW_NONE,
    rs:   {SHADOW_REG_W{1'b0}},
    rt:   {SHADOW_REG_W{1'b0}}
  };

  // One cycle closer to the result; 0 and 3 (no write) are sticky.
  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    logic [1:0] r;
    case (t)
      2'd1:    r = 2'd0;
      2'd2:    r = 2'd1;
      default: r = t;
    endcase
    return r;
  endfunction

  // Entry produces register r and its value already exists.
  function automatic logic fwd_hit(input logic [SHADOW_REG_W-1:0] r,
                                   input shadow_t ent);
    return (r != {SHADOW_REG_W{1'b0}}) && (ent.dst == r) && (ent.tnew == 2'd0);
  endfunction

  // Entry produces register r later than the consumer needs it.
  function automatic logic stall_hit(input logic [SHADOW_REG_W-1:0] r,
                                     input logic [1:0] tuse,
                                     input shadow_t ent);
    return (tuse != TUSE_NONE) && (r != {SHADOW_REG_W{1'b0}}) &&
           (ent.dst == r) && (ent.tnew != TNEW_NONE) && (ent.tnew > tuse);
  endfunction

  // D-stage operand source, youngest ready producer first.
  function automatic logic [1:0] fwd_sel_d(input logic [SHADOW_REG_W-1:0] r,
                                           input shadow_t e,
                                           input shadow_t m,
                                           input shadow_t w);
    logic [1:0] sel;
    if (fwd_hit(r, e))      sel = FWD_E;
    else if (fwd_hit(r, m)) sel = FWD_M;
    else if (fwd_hit(r, w)) sel = FWD_W;
    else                    sel = FWD_RF;
    return sel;
  endfunction

  // E-stage operand source: M before W.
  function automatic logic [1:0] fwd_sel_e(input logic [SHADOW_REG_W-1:0] r,
                                           input shadow_t m,
                                           input shadow_t w);
    logic [1:0] sel;
    if (fwd_hit(r, m))      sel = FWD_M;
    else if (fwd_hit(r, w)) sel = FWD_W;
    else                    sel = FWD_RF;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// hazard_stage_reg: one shadow-pipeline entry (E, M or W). Loads the entry
// from the previous stage each cycle, optionally counting tnew down, or
// takes a bubble.
module hazard_stage_reg
  import hazard_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    bubble,
  input  logic    dec,
  input  shadow_t d,
  output shadow_t q
);

  // Advance the entry: clear on reset or bubble, otherwise load with countdown
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= SHADOW_EMPTY;
    end else if (bubble) begin
      q <= SHADOW_EMPTY;
    end else begin
      q.dst  <= d.dst;
      q.rs   <= d.rs;
      q.rt   <= d.rt;
      q.tnew <= dec ? tnew_dec(d.tnew) : d.tnew;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall and forwarding controller for the five-stage pipeline.
// Keeps a shadow E/M/W pipeline of destination + remaining-Tnew and decides
// stall and forwarding selects combinationally from the D-stage codes.
// Optional build macro HAZARD_STATS_EN adds a 32-bit stall-cycle counter
// output stall_cnt.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic [1:0]       tuse_rs,
  input  logic [1:0]       tuse_rt,
  input  logic [1:0]       tnew_d,
  input  logic [REG_W-1:0] dst_d,
  output logic             stall,
  output logic [1:0]       fwd_rs_d,
  output logic [1:0]       fwd_rt_d,
  output logic [1:0]       fwd_rs_e,
  output logic [1:0]       fwd_rt_e,
  output logic             fwd_rt_m
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  shadow_t                 ent_d;
  shadow_t                 ent_e;
  shadow_t                 ent_m;
  shadow_t                 ent_w;
  logic [SHADOW_REG_W-1:0] rs_x;
  logic [SHADOW_REG_W-1:0] rt_x;
  logic                    stall_rs;
  logic                    stall_rt;
  logic                    unused_bits;

  // Bring the D-stage fields into shadow-entry form
  always_comb begin
    rs_x       = SHADOW_REG_W'(rs_d);
    rt_x       = SHADOW_REG_W'(rt_d);
    ent_d.dst  = SHADOW_REG_W'(dst_d);
    ent_d.tnew = tnew_d;
    ent_d.rs   = rs_x;
    ent_d.rt   = rt_x;
  end

  // E takes D (or a bubble while D stalls); tnew is counted from E entry
  hazard_stage_reg u_stage_e (
    .clk    (clk),
    .reset  (reset),
    .bubble (stall),
    .dec    (1'b0),
    .d      (ent_d),
    .q      (ent_e)
  );

  hazard_stage_reg u_stage_m (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .dec    (1'b1),
    .d      (ent_e),
    .q      (ent_m)
  );

  hazard_stage_reg u_stage_w (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .dec    (1'b1),
    .d      (ent_m),
    .q      (ent_w)
  );

  // Stall when an E or M producer cannot deliver before D's operand is used
  always_comb begin
    stall_rs = stall_hit(rs_x, tuse_rs, ent_e) | stall_hit(rs_x, tuse_rs, ent_m);
    stall_rt = stall_hit(rt_x, tuse_rt, ent_e) | stall_hit(rt_x, tuse_rt, ent_m);
    stall    = stall_rs | stall_rt;
  end

  // Forwarding selects for the D, E and M operand consumers
  always_comb begin
    fwd_rs_d = fwd_sel_d(rs_x, ent_e, ent_m, ent_w);
    fwd_rt_d = fwd_sel_d(rt_x, ent_e, ent_m, ent_w);
    fwd_rs_e = fwd_sel_e(ent_e.rs, ent_m, ent_w);
    fwd_rt_e = fwd_sel_e(ent_e.rt, ent_m, ent_w);
    fwd_rt_m = fwd_hit(ent_m.rt, ent_w);
  end

  // Source fields that travel with the entry but have no consumer in M/W
  assign unused_bits = ^{ent_m.rs, ent_w.rs, ent_w.rt};

`ifdef HAZARD_STATS_EN
  // Count stalled cycles, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end
`endif

endmodule
